uart_frame_decoder: RTL and testbench
=====================================

// Module: uart_frame_decoder
// PURPOSE
//  Consumes the byte stream produced by the UART receiver (1-cycle new_data strobe + byte).
//  Delineates frames: SYNC(0xA5), CMD, LEN, LEN payload bytes, CHK.
//  Buffers the payload and presents validated frames to the control logic via valid/ack.
//  Flags checksum, length, inter-byte timeout and overrun errors; resynchronises on SYNC.
// PARAMETERS
//  INPUT_CLOCK_FREQ  100_000_000  clk_in frequency, Hz
//  BAUD_RATE         9600         line rate; used only for timeout sizing
//  MAX_PAYLOAD       16           max LEN accepted (>=1)
//  TIMEOUT_BYTES     4            allowed mid-frame gap, in 10-bit character times
// PORTS
//  clk_in           in   1        system clock
//  rst_n_in         in   1        asynchronous, active-low reset
//  new_data_in      in   1        1-cycle strobe: data_byte_in valid
//  data_byte_in     in   8        received byte
//  frame_valid_out  out  1        validated frame held; high until acked
//  frame_cmd_out    out  8        CMD byte of held frame
//  frame_len_out    out  LEN_W    LEN of held frame; LEN_W=$clog2(MAX_PAYLOAD+1)
//  frame_ack_in     in   1        consumer done with held frame
//  rd_addr_in       in   ADDR_W   payload index; ADDR_W=$clog2(MAX_PAYLOAD), min 1
//  rd_data_out      out  8        payload[rd_addr_in], registered, 1-cycle latency
//  err_valid_out    out  1        1-cycle error strobe
//  err_code_out     out  2        0 CHECKSUM, 1 LENGTH, 2 TIMEOUT, 3 OVERRUN; held until next err
//  busy_out         out  1        state != HUNT
// BEHAVIOUR
//  Reset: state=HUNT; all outputs, counters and running sum are 0. Buffer RAM is not reset.
//  Reset mid-frame discards the partial frame and any held frame.
//  FSM advances only on new_data_in, except HOLD exit and timeout.
//  - HUNT: byte==0xA5 -> CMD, sum=0. Other bytes are dropped silently.
//  - CMD: latch cmd, sum+=byte -> LEN. Any value is accepted, including 0xA5.
//  - LEN: byte==0 or >MAX_PAYLOAD -> err LENGTH, HUNT.
//    Otherwise latch len, sum+=byte, idx=0 -> PAYLOAD.
//  - PAYLOAD: buf[idx]=byte, sum+=byte, idx++.
//    At idx==len-1 -> CHECK.
//  - CHECK: if (sum+byte)[7:0]==0 -> HOLD, and frame_valid_out=1 on the next edge.
//    Otherwise err CHECKSUM -> HUNT.
//  - HOLD: frame_cmd_out/frame_len_out/buffer are stable.
//    On frame_ack_in: frame_valid_out=0 next edge -> HUNT.
//    new_data_in without ack: byte dropped, err OVERRUN, stay in HOLD.
//    new_data_in with ack in the same cycle: byte dropped, no error.
//  frame_ack_in outside HOLD is ignored.
//  Sum is 8-bit, mod 256, over CMD+LEN+payload. The sender sets CHK = -sum.
//  Timeout: gap counter clears on every new_data_in and counts in CMD/LEN/PAYLOAD/CHECK.
//    At TIMEOUT_CYCLES-1 -> err TIMEOUT, HUNT.
//    TIMEOUT_CYCLES = TIMEOUT_BYTES*10*ceil(INPUT_CLOCK_FREQ/BAUD_RATE).
//    The counter is idle and held at 0 in HUNT and HOLD.
//  A timeout and a byte in the same cycle: the byte wins, no timeout.
//  err_valid_out pulses exactly one cycle per error. err_code_out updates in the same cycle.
//  rd_data_out is valid one cycle after rd_addr_in. Reads at idx >= frame_len_out are undefined.
//  No combinational path from any input to any output.
// STRUCTURE
//  uart_frame_pkg:
//    SYNC_BYTE=8'hA5, state enum {HUNT,CMD,LEN,PAYLOAD,CHECK,HOLD},
//    err_code_t {ERR_CHECKSUM,ERR_LENGTH,ERR_TIMEOUT,ERR_OVERRUN}.
//  Sub-module uart_frame_buffer: MAX_PAYLOAD x 8 RAM, 1 write port + 1 registered read port.
//    Infers distributed/BRAM.
//  Top level holds the FSM, running sum, index, gap counter and output registers.
// TESTING
//  Bench overrides: INPUT_CLOCK_FREQ=1000, BAUD_RATE=100, TIMEOUT_BYTES=1 -> TIMEOUT_CYCLES=100.
//  1 Good frame:
//      Bytes A5 10 03 11 22 33 87 -> frame_valid=1 one cycle after the 0x87 strobe.
//      cmd=0x10, len=3; rd 0,1,2 -> 11,22,33.
//      Ack -> valid=0, busy=0.
//  2 Bad checksum:
//      A5 10 03 11 22 33 88 -> err_valid pulse, code=0, no frame_valid, busy=0.
//  3 Length errors:
//      A5 10 00 -> code=1.
//      A5 10 11, with MAX_PAYLOAD=16 -> code=1.
//      Following A5 01 01 55 A9 -> valid frame, payload 55.
//  4 Timeout and resync:
//      Bytes 12 34 ignored.
//      A5 10, then 100 idle cycles -> code=2, busy=0.
//      A 99-cycle gap must not trigger.
//  5 Overrun:
//      Hold frame from test 1 unacked, send A5 -> code=3, contents unchanged.
//      Ack coincident with a byte -> no error, HUNT.
//  6 Async reset:
//      rst_n_in low mid-PAYLOAD, off-edge -> outputs 0 immediately.
//      After release, a full good frame decodes.

Source files
------------

// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_pkg
//  Description : Shared constants and types for the UART frame decoder:
//                sync byte, FSM state encoding, error codes and a small
//                ceiling-division helper used for timeout sizing.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4,
        HOLD    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_CHECKSUM = 2'd0,
        ERR_LENGTH   = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_OVERRUN  = 2'd3
    } err_code_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_decoder_if
//  Description : Bundles the decoder's byte input, held-frame handshake,
//                payload read port and error/status outputs.
//                slave  : decoder side
//                master : byte source / frame consumer side
//  Ports       : new_data_in, data_byte_in        - received byte + strobe
//                frame_valid_out/cmd/len, ack_in  - held frame handshake
//                rd_addr_in, rd_data_out          - payload read (1-cycle)
//                err_valid_out, err_code_out      - error strobe + code
//                busy_out                         - decoder not hunting
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_frame_decoder_if #(
    parameter int MAX_PAYLOAD = 16
);
    localparam int LEN_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int ADDR_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    logic              new_data_in;
    logic [7:0]        data_byte_in;
    logic              frame_valid_out;
    logic [7:0]        frame_cmd_out;
    logic [LEN_W-1:0]  frame_len_out;
    logic              frame_ack_in;
    logic [ADDR_W-1:0] rd_addr_in;
    logic [7:0]        rd_data_out;
    logic              err_valid_out;
    logic [1:0]        err_code_out;
    logic              busy_out;

    modport slave (
        input  new_data_in, data_byte_in, frame_ack_in, rd_addr_in,
        output frame_valid_out, frame_cmd_out, frame_len_out, rd_data_out,
               err_valid_out, err_code_out, busy_out
    );

    modport master (
        output new_data_in, data_byte_in, frame_ack_in, rd_addr_in,
        input  frame_valid_out, frame_cmd_out, frame_len_out, rd_data_out,
               err_valid_out, err_code_out, busy_out
    );

endinterface
`default_nettype wire

// File: rtl/uart_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_buffer
//  Description : DEPTH x 8 payload RAM, one write port and one registered
//                read port (1-cycle latency). Array contents are not reset,
//                only the read register, so the array maps onto RAM.
//  Ports       : clk_in, rst_n_in            - clock, async active-low reset
//                wr_en_in/wr_addr_in/wr_data_in - write port
//                rd_addr_in/rd_data_out      - registered read port
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk_in,
    input  wire logic              rst_n_in,
    input  wire logic              wr_en_in,
    input  wire logic [ADDR_W-1:0] wr_addr_in,
    input  wire logic [7:0]        wr_data_in,
    input  wire logic [ADDR_W-1:0] rd_addr_in,
    output logic      [7:0]        rd_data_out
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            r_mem[wr_addr_in] <= wr_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_mem[rd_addr_in];
        end
    end

    assign rd_data_out = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_decoder
//  Description : Delineates SYNC/CMD/LEN/payload/CHK frames from a UART byte
//                stream, buffers the payload and holds a validated frame
//                until acknowledged. Reports checksum, length, inter-byte
//                timeout and overrun errors as one-cycle strobes.
//  Ports       : clk_in   - system clock
//                rst_n_in - asynchronous active-low reset
//                bus      - uart_frame_decoder_if.slave (see interface)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int MAX_PAYLOAD      = 16,
    parameter int TIMEOUT_BYTES    = 4
) (
    input wire logic        clk_in,
    input wire logic        rst_n_in,
    uart_frame_decoder_if.slave bus
);

    localparam int c_len_w          = $clog2(MAX_PAYLOAD + 1);
    localparam int c_addr_w         = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    // One character is 10 bit times (start + 8 data + stop).
    localparam int c_timeout_cycles = TIMEOUT_BYTES * 10 * ceil_div(INPUT_CLOCK_FREQ, BAUD_RATE);
    localparam int c_gap_w          = $clog2(c_timeout_cycles + 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(c_timeout_cycles - 1);
    localparam logic [8:0]         c_max_len  = 9'(MAX_PAYLOAD);

    state_t               r_state,       w_state_nxt;
    logic [7:0]           r_sum,         w_sum_nxt;
    logic [7:0]           r_cmd,         w_cmd_nxt;
    logic [c_len_w-1:0]   r_len,         w_len_nxt;
    logic [c_len_w-1:0]   r_idx,         w_idx_nxt;
    logic [c_gap_w-1:0]   r_gap,         w_gap_nxt;
    logic                 r_frame_valid, w_frame_valid_nxt;
    logic                 r_err_valid,   w_err_valid_nxt;
    err_code_t            r_err_code,    w_err_code_nxt;

    logic                 w_wr_en;
    logic                 w_counting;
    logic                 w_timeout;
    logic [7:0]           w_sum_add;
    logic [7:0]           w_rd_data;

    assign w_sum_add = r_sum + bus.data_byte_in;

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_sum_nxt         = r_sum;
        w_cmd_nxt         = r_cmd;
        w_len_nxt         = r_len;
        w_idx_nxt         = r_idx;
        w_frame_valid_nxt = r_frame_valid;
        w_err_valid_nxt   = 1'b0;
        w_err_code_nxt    = r_err_code;
        w_wr_en           = 1'b0;

        // Gap counter runs only while a frame is being assembled; any byte
        // restarts it, and a byte arriving on the last count beats the timeout.
        w_counting = (r_state == CMD) || (r_state == LEN) ||
                     (r_state == PAYLOAD) || (r_state == CHECK);
        w_timeout  = w_counting && !bus.new_data_in && (r_gap == c_gap_last);
        w_gap_nxt  = (w_counting && !bus.new_data_in) ? r_gap + c_gap_w'(1)
                                                      : '0;

        if (w_timeout) begin
            w_state_nxt     = HUNT;
            w_err_valid_nxt = 1'b1;
            w_err_code_nxt  = ERR_TIMEOUT;
            w_gap_nxt       = '0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (bus.new_data_in && (bus.data_byte_in == SYNC_BYTE)) begin
                        w_state_nxt = CMD;
                        w_sum_nxt   = 8'h00;
                    end
                end
                CMD: begin
                    if (bus.new_data_in) begin
                        w_cmd_nxt   = bus.data_byte_in;
                        w_sum_nxt   = w_sum_add;
                        w_state_nxt = LEN;
                    end
                end
                LEN: begin
                    if (bus.new_data_in) begin
                        if ((bus.data_byte_in == 8'h00) ||
                            ({1'b0, bus.data_byte_in} > c_max_len)) begin
                            w_state_nxt     = HUNT;
                            w_err_valid_nxt = 1'b1;
                            w_err_code_nxt  = ERR_LENGTH;
                        end else begin
                            w_len_nxt   = c_len_w'(bus.data_byte_in);
                            w_sum_nxt   = w_sum_add;
                            w_idx_nxt   = '0;
                            w_state_nxt = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.new_data_in) begin
                        w_wr_en   = 1'b1;
                        w_sum_nxt = w_sum_add;
                        w_idx_nxt = r_idx + c_len_w'(1);
                        if (r_idx == (r_len - c_len_w'(1))) begin
                            w_state_nxt = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (bus.new_data_in) begin
                        // Sender sets CHK = -sum, so a good frame sums to zero.
                        if (w_sum_add == 8'h00) begin
                            w_state_nxt       = HOLD;
                            w_frame_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt     = HUNT;
                            w_err_valid_nxt = 1'b1;
                            w_err_code_nxt  = ERR_CHECKSUM;
                        end
                    end
                end
                HOLD: begin
                    // Bytes are never written in HOLD, so the buffer stays put;
                    // a byte together with the ack is dropped without complaint.
                    if (bus.frame_ack_in) begin
                        w_frame_valid_nxt = 1'b0;
                        w_state_nxt       = HUNT;
                    end else if (bus.new_data_in) begin
                        w_err_valid_nxt = 1'b1;
                        w_err_code_nxt  = ERR_OVERRUN;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= HUNT;
            r_sum         <= 8'h00;
            r_cmd         <= 8'h00;
            r_len         <= '0;
            r_idx         <= '0;
            r_gap         <= '0;
            r_frame_valid <= 1'b0;
            r_err_valid   <= 1'b0;
            r_err_code    <= ERR_CHECKSUM;
        end else begin
            r_state       <= w_state_nxt;
            r_sum         <= w_sum_nxt;
            r_cmd         <= w_cmd_nxt;
            r_len         <= w_len_nxt;
            r_idx         <= w_idx_nxt;
            r_gap         <= w_gap_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_err_valid   <= w_err_valid_nxt;
            r_err_code    <= w_err_code_nxt;
        end
    end

    uart_frame_buffer #(
        .DEPTH  (MAX_PAYLOAD),
        .ADDR_W (c_addr_w)
    ) u_buffer (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .wr_en_in    (w_wr_en),
        .wr_addr_in  (c_addr_w'(r_idx)),
        .wr_data_in  (bus.data_byte_in),
        .rd_addr_in  (bus.rd_addr_in),
        .rd_data_out (w_rd_data)
    );

    assign bus.frame_valid_out = r_frame_valid;
    assign bus.frame_cmd_out   = r_cmd;
    assign bus.frame_len_out   = r_len;
    assign bus.rd_data_out     = w_rd_data;
    assign bus.err_valid_out   = r_err_valid;
    assign bus.err_code_out    = r_err_code;
    assign bus.busy_out        = (r_state != HUNT);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_decoder
//  Description : Directed bench for uart_frame_decoder. Expected frames and
//                errors are queued by the stimulus; a monitor pops them when
//                the decoder raises frame_valid or err_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_frame_decoder;

    typedef struct packed {
        logic [7:0] cmd;
        logic [4:0] len;
    } exp_frame_t;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [1:0] err_q[$];
    exp_frame_t frame_q[$];

    uart_frame_decoder_if #(.MAX_PAYLOAD(16)) bus ();

    uart_frame_decoder #(
        .INPUT_CLOCK_FREQ (1000),
        .BAUD_RATE        (100),
        .MAX_PAYLOAD      (16),
        .TIMEOUT_BYTES    (1)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.new_data_in  = 1'b1;
        bus.data_byte_in = b;
        @(negedge clk);
        bus.new_data_in  = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        bus.frame_ack_in = 1'b1;
        @(negedge clk);
        bus.frame_ack_in = 1'b0;
    endtask

    task automatic ack_with_byte(input logic [7:0] b);
        @(negedge clk);
        bus.frame_ack_in = 1'b1;
        bus.new_data_in  = 1'b1;
        bus.data_byte_in = b;
        @(negedge clk);
        bus.frame_ack_in = 1'b0;
        bus.new_data_in  = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] addr, input logic [7:0] exp);
        @(negedge clk);
        bus.rd_addr_in = addr;
        @(negedge clk);
        check(name, 32'(bus.rd_data_out), 32'(exp));
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.err_valid_out) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_err: got code %0d, expected no error", bus.err_code_out);
                end else begin
                    check("err_code", 32'(bus.err_code_out), 32'(err_q.pop_front()));
                end
            end
            if (bus.frame_valid_out && !prev_valid) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got cmd 0x%0h len %0d, expected no frame",
                             bus.frame_cmd_out, bus.frame_len_out);
                end else begin
                    exp_frame_t f;
                    f = frame_q.pop_front();
                    check("frame_cmd", 32'(bus.frame_cmd_out), 32'(f.cmd));
                    check("frame_len", 32'(bus.frame_len_out), 32'(f.len));
                end
            end
            prev_valid = bus.frame_valid_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n            = 1'b0;
        bus.new_data_in  = 1'b0;
        bus.data_byte_in = 8'h00;
        bus.frame_ack_in = 1'b0;
        bus.rd_addr_in   = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_valid",    32'(bus.frame_valid_out), 32'd0);
        check("rst_busy",     32'(bus.busy_out),        32'd0);
        check("rst_err_valid",32'(bus.err_valid_out),   32'd0);
        check("rst_err_code", 32'(bus.err_code_out),    32'd0);
        check("rst_cmd",      32'(bus.frame_cmd_out),   32'd0);
        check("rst_len",      32'(bus.frame_len_out),   32'd0);
        check("rst_rd_data",  32'(bus.rd_data_out),     32'd0);
        rst_n = 1'b1;

        // 1: good frame
        frame_q.push_back('{cmd: 8'h10, len: 5'd3});
        send(8'hA5); send(8'h10); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
        check("t1_busy",          32'(bus.busy_out),        32'd1);
        check("t1_valid_before",  32'(bus.frame_valid_out), 32'd0);
        send(8'h87);
        check("t1_valid_latency", 32'(bus.frame_valid_out), 32'd1);
        rd_check("t1_rd0", 4'd0, 8'h11);
        rd_check("t1_rd1", 4'd1, 8'h22);
        rd_check("t1_rd2", 4'd2, 8'h33);

        // 5a: overrun while held
        err_q.push_back(2'd3);
        send(8'hA5);
        check("t5_valid_kept", 32'(bus.frame_valid_out), 32'd1);
        check("t5_busy_kept",  32'(bus.busy_out),        32'd1);
        check("t5_cmd_kept",   32'(bus.frame_cmd_out),   32'h10);
        check("t5_len_kept",   32'(bus.frame_len_out),   32'd3);
        rd_check("t5_rd0", 4'd0, 8'h11);
        rd_check("t5_rd2", 4'd2, 8'h33);
        ack();
        check("t1_ack_valid", 32'(bus.frame_valid_out), 32'd0);
        check("t1_ack_busy",  32'(bus.busy_out),        32'd0);

        // 2: bad checksum
        err_q.push_back(2'd0);
        send(8'hA5); send(8'h10); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h88);
        check("t2_valid", 32'(bus.frame_valid_out), 32'd0);
        check("t2_busy",  32'(bus.busy_out),        32'd0);

        // 3: length errors, then a one-byte frame
        err_q.push_back(2'd1);
        send(8'hA5); send(8'h10); send(8'h00);
        check("t3_len0_busy", 32'(bus.busy_out), 32'd0);
        err_q.push_back(2'd1);
        send(8'hA5); send(8'h10); send(8'h11);
        check("t3_len17_busy", 32'(bus.busy_out), 32'd0);
        frame_q.push_back('{cmd: 8'h01, len: 5'd1});
        send(8'hA5); send(8'h01); send(8'h01); send(8'h55); send(8'hA9);
        check("t3_valid", 32'(bus.frame_valid_out), 32'd1);
        rd_check("t3_rd0", 4'd0, 8'h55);

        // 5b: ack coincident with a byte drops the byte silently
        ack_with_byte(8'hA5);
        check("t5_ackbyte_valid", 32'(bus.frame_valid_out), 32'd0);
        check("t5_ackbyte_busy",  32'(bus.busy_out),        32'd0);

        // 4: junk ignored, timeout after 100 idle cycles
        send(8'h12); send(8'h34);
        check("t4_junk_busy", 32'(bus.busy_out), 32'd0);
        err_q.push_back(2'd2);
        send(8'hA5); send(8'h10);
        repeat (99) @(negedge clk);
        check("t4_busy_at_99", 32'(bus.busy_out), 32'd1);
        @(negedge clk);
        check("t4_busy_at_100", 32'(bus.busy_out),     32'd0);
        check("t4_err_code",    32'(bus.err_code_out), 32'd2);

        // 4b: a 99-cycle gap does not trigger
        frame_q.push_back('{cmd: 8'h10, len: 5'd1});
        send(8'hA5); send(8'h10);
        repeat (98) @(negedge clk);
        send(8'h01); send(8'h42); send(8'hAD);
        check("t4_gap99_valid", 32'(bus.frame_valid_out), 32'd1);
        rd_check("t4_gap99_rd0", 4'd0, 8'h42);
        ack();

        // 6: async reset mid-payload, off-edge
        bus.rd_addr_in = 4'd0;
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11);
        check("t6_busy_pre", 32'(bus.busy_out), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",     32'(bus.busy_out),        32'd0);
        check("t6_rst_valid",    32'(bus.frame_valid_out), 32'd0);
        check("t6_rst_cmd",      32'(bus.frame_cmd_out),   32'd0);
        check("t6_rst_len",      32'(bus.frame_len_out),   32'd0);
        check("t6_rst_err_code", 32'(bus.err_code_out),    32'd0);
        check("t6_rst_rd_data",  32'(bus.rd_data_out),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_q.push_back('{cmd: 8'h10, len: 5'd3});
        send(8'hA5); send(8'h10); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h87);
        check("t6_valid", 32'(bus.frame_valid_out), 32'd1);
        rd_check("t6_rd1", 4'd1, 8'h22);
        ack();

        repeat (3) @(negedge clk);
        check("final_err_q_empty",   32'(err_q.size()),   32'd0);
        check("final_frame_q_empty", 32'(frame_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
